// File: rtl/cp_remove_tagger_if.sv
// Stream bundle for cp_remove_tagger: time-domain IQ in, CP-stripped tagged symbols out.
// Status signals exist only when CP_REMOVE_TAGGER_STATUS_EN is defined.
interface cp_remove_tagger_if;
    logic        sync_in;
    logic        din_valid;
    logic [15:0] din_real;
    logic [15:0] din_imag;
    logic        dout_valid;
    logic        dout_sop;
    logic        dout_eop;
    logic [15:0] dout_real;
    logic [15:0] dout_imag;
    logic [3:0]  dout_symbol;
    logic [7:0]  dout_slot;
    logic        sync_err;
`ifdef CP_REMOVE_TAGGER_STATUS_EN
    logic [31:0] sym_cnt;
    logic [0:0]  sync_lost;
`endif

`ifdef CP_REMOVE_TAGGER_STATUS_EN
    modport master (
        output sync_in, din_valid, din_real, din_imag,
        input  dout_valid, dout_sop, dout_eop, dout_real, dout_imag,
        input  dout_symbol, dout_slot, sync_err, sym_cnt, sync_lost
    );
    modport slave (
        input  sync_in, din_valid, din_real, din_imag,
        output dout_valid, dout_sop, dout_eop, dout_real, dout_imag,
        output dout_symbol, dout_slot, sync_err, sym_cnt, sync_lost
    );
`else
    modport master (
        output sync_in, din_valid, din_real, din_imag,
        input  dout_valid, dout_sop, dout_eop, dout_real, dout_imag,
        input  dout_symbol, dout_slot, sync_err
    );
    modport slave (
        input  sync_in, din_valid, din_real, din_imag,
        output dout_valid, dout_sop, dout_eop, dout_real, dout_imag,
        output dout_symbol, dout_slot, sync_err
    );
`endif
endinterface

// File: rtl/cp_remove_tagger.sv
// Cyclic-prefix removal ahead of per-symbol phase compensation.
// Drops the long CP on symbol 0 of each slot and the short CP otherwise, forwards
// FFT_SIZE useful samples per symbol with sop/eop and symbol/slot tags, 1-clk latency.
// Optional status outputs (sym_cnt, sync_lost) under CP_REMOVE_TAGGER_STATUS_EN.
module cp_remove_tagger #(
    parameter int unsigned FFT_SIZE     = 4096,
    parameter int unsigned CP_LONG      = 352,
    parameter int unsigned CP_SHORT     = 288,
    parameter int unsigned SYM_PER_SLOT = 14,
    parameter int unsigned SLOT_NUM     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    cp_remove_tagger_if.slave  bus
);
    localparam int unsigned CP_MAX  = (CP_LONG > CP_SHORT) ? CP_LONG : CP_SHORT;
    localparam int unsigned CNT_MAX = (FFT_SIZE > CP_MAX) ? FFT_SIZE : CP_MAX;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned SYM_W   = 4;
    localparam int unsigned SLOT_W  = 8;

    typedef enum logic [1:0] {IDLE, CP, DATA} state_t;

    state_t              state_q, state_d, cur_state;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cur_cnt, cp_last;
    logic [SYM_W-1:0]    symbol_q, symbol_d, cur_symbol;
    logic [SLOT_W-1:0]   slot_q, slot_d, cur_slot;
    logic                fwd, sop_d, eop_d, err_d;

    // Next-state and beat decode; a qualified sync re-enters as CP sample 0 of symbol 0, slot 0.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        symbol_d   = symbol_q;
        slot_d     = slot_q;
        fwd        = 1'b0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        err_d      = 1'b0;
        cur_state  = state_q;
        cur_cnt    = cnt_q;
        cur_symbol = symbol_q;
        cur_slot   = slot_q;
        cp_last    = '0;
        if (bus.din_valid) begin
            if (bus.sync_in) begin
                // On-boundary sync (or first sync from IDLE) is silent.
                err_d = (state_q != IDLE) &&
                        !(state_q == CP && cnt_q == '0 && symbol_q == '0 && slot_q == '0);
                cur_state  = CP;
                cur_cnt    = '0;
                cur_symbol = '0;
                cur_slot   = '0;
                symbol_d   = '0;
                slot_d     = '0;
            end
            cp_last = (cur_symbol == '0) ? CNT_W'(CP_LONG - 1) : CNT_W'(CP_SHORT - 1);
            unique case (cur_state)
                IDLE: state_d = IDLE;
                CP: begin
                    state_d = CP;
                    if (cur_cnt == cp_last) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cur_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    fwd   = 1'b1;
                    sop_d = (cur_cnt == '0);
                    if (cur_cnt == CNT_W'(FFT_SIZE - 1)) begin
                        eop_d   = 1'b1;
                        state_d = CP;
                        cnt_d   = '0;
                        if (cur_symbol == SYM_W'(SYM_PER_SLOT - 1)) begin
                            symbol_d = '0;
                            slot_d   = (cur_slot == SLOT_W'(SLOT_NUM - 1)) ? '0 : cur_slot + SLOT_W'(1);
                        end else begin
                            symbol_d = cur_symbol + SYM_W'(1);
                        end
                    end else begin
                        cnt_d = cur_cnt + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            symbol_q <= '0;
            slot_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            symbol_q <= symbol_d;
            slot_q   <= slot_d;
        end
    end

    // Registered outputs; payload and tags only move on forwarded beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout_valid  <= 1'b0;
            bus.dout_sop    <= 1'b0;
            bus.dout_eop    <= 1'b0;
            bus.dout_real   <= '0;
            bus.dout_imag   <= '0;
            bus.dout_symbol <= '0;
            bus.dout_slot   <= '0;
            bus.sync_err    <= 1'b0;
        end else begin
            bus.dout_valid <= fwd;
            bus.dout_sop   <= sop_d;
            bus.dout_eop   <= eop_d;
            bus.sync_err   <= err_d;
            if (fwd) begin
                bus.dout_real   <= bus.din_real;
                bus.dout_imag   <= bus.din_imag;
                bus.dout_symbol <= cur_symbol;
                bus.dout_slot   <= cur_slot;
            end
        end
    end

`ifdef CP_REMOVE_TAGGER_STATUS_EN
    // Completed-symbol counter and sticky sync-loss flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sym_cnt   <= '0;
            bus.sync_lost <= '0;
        end else begin
            if (eop_d) begin
                bus.sym_cnt <= bus.sym_cnt + 32'(1);
            end
            if (err_d) begin
                bus.sync_lost <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cp_remove_tagger.sv
// Directed bench for cp_remove_tagger with FFT_SIZE=16, CP_LONG=6, CP_SHORT=4, 14 symbols, 2 slots.
module tb_cp_remove_tagger;
    localparam int unsigned FFT  = 16;
    localparam int unsigned CPL  = 6;
    localparam int unsigned CPS  = 4;
    localparam int unsigned SLOT_LEN = CPL + FFT + 13 * (CPS + FFT);  // 282

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   sop_n;
    int   eop_n;
    int   beats;

    cp_remove_tagger_if bus ();

    cp_remove_tagger #(
        .FFT_SIZE     (FFT),
        .CP_LONG      (CPL),
        .CP_SHORT     (CPS),
        .SYM_PER_SLOT (14),
        .SLOT_NUM     (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected framing for sample n after a sync at n=0 with continuous slots.
    task automatic model(input int n, output logic v, output logic s, output logic e,
                         output logic [3:0] sym, output logic [7:0] slot);
        int p, q, r;
        p    = n % SLOT_LEN;
        slot = 8'((n / SLOT_LEN) % 2);
        v = 1'b0; s = 1'b0; e = 1'b0; sym = 4'd0;
        if (p >= CPL && p < CPL + FFT) begin
            v = 1'b1;
            s = (p == CPL);
            e = (p == CPL + FFT - 1);
        end else if (p >= CPL + FFT) begin
            q   = p - (CPL + FFT);
            sym = 4'(1 + q / (CPS + FFT));
            r   = q % (CPS + FFT);
            if (r >= CPS) begin
                v = 1'b1;
                s = (r == CPS);
                e = (r == CPS + FFT - 1);
            end
        end
    endtask

    task automatic step(input logic s, input logic v, input logic [15:0] re, input logic [15:0] im);
        bus.sync_in   = s;
        bus.din_valid = v;
        bus.din_real  = re;
        bus.din_imag  = im;
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input int n, input logic [15:0] re,
                              input logic [15:0] im, input logic exp_err);
        logic ev, es, ee;
        logic [3:0] esym;
        logic [7:0] eslot;
        model(n, ev, es, ee, esym, eslot);
        check({tag, "_valid"}, 32'(bus.dout_valid), 32'(ev));
        check({tag, "_sop"}, 32'(bus.dout_sop), 32'(es));
        check({tag, "_eop"}, 32'(bus.dout_eop), 32'(ee));
        check({tag, "_err"}, 32'(bus.sync_err), 32'(exp_err));
        if (ev) begin
            check({tag, "_real"}, 32'(bus.dout_real), 32'(re));
            check({tag, "_imag"}, 32'(bus.dout_imag), 32'(im));
            check({tag, "_sym"}, 32'(bus.dout_symbol), 32'(esym));
            check({tag, "_slot"}, 32'(bus.dout_slot), 32'(eslot));
        end
        if (bus.dout_valid === 1'b1) begin
            beats = (bus.dout_sop === 1'b1) ? 1 : beats + 1;
            if (bus.dout_sop === 1'b1) sop_n++;
            if (bus.dout_eop === 1'b1) begin
                eop_n++;
                check({tag, "_symlen"}, 32'(beats), 32'(FFT));
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, 32'(bus.dout_valid), 32'd0);
        check({tag, "_sop"}, 32'(bus.dout_sop), 32'd0);
        check({tag, "_eop"}, 32'(bus.dout_eop), 32'd0);
        check({tag, "_err"}, 32'(bus.sync_err), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check_quiet(tag);
        check({tag, "_real"}, 32'(bus.dout_real), 32'd0);
        check({tag, "_imag"}, 32'(bus.dout_imag), 32'd0);
        check({tag, "_sym"}, 32'(bus.dout_symbol), 32'd0);
        check({tag, "_slot"}, 32'(bus.dout_slot), 32'd0);
`ifdef CP_REMOVE_TAGGER_STATUS_EN
        check({tag, "_symcnt"}, bus.sym_cnt, 32'd0);
        check({tag, "_lost"}, 32'(bus.sync_lost), 32'd0);
`endif
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.sync_in   = 1'b0;
        bus.din_valid = 1'b0;
        bus.din_real  = '0;
        bus.din_imag  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int m;
        logic v;
        logic [15:0] re;
        errors = 0;
        checks = 0;
        sop_n  = 0;
        eop_n  = 0;
        beats  = 0;

        // Continuous ramp over four slots, re-synced exactly on the boundary every two slots.
        do_reset();
        for (int i = 0; i < 4 * SLOT_LEN + 30; i++) begin
            re = 16'(i);
            step((i % (2 * SLOT_LEN)) == 0, 1'b1, re, re ^ 16'h5a5a);
            check_beat("ramp", i, re, re ^ 16'h5a5a, 1'b0);
            if (i == CPL) begin
                check("first_sop_data", 32'(bus.dout_real), 32'd6);
                check("first_sop_flag", 32'(bus.dout_sop), 32'd1);
            end
            if (i == 26) begin
                check("sym1_sop_data", 32'(bus.dout_real), 32'd26);
                check("sym1_sop_tag", 32'(bus.dout_symbol), 32'd1);
            end
            if (i == 2 * SLOT_LEN - 1) begin
                check("sop_per_2slots", 32'(sop_n), 32'd28);
                check("eop_per_2slots", 32'(eop_n), 32'd28);
            end
        end
`ifdef CP_REMOVE_TAGGER_STATUS_EN
        check("ramp_symcnt", bus.sym_cnt, 32'(eop_n));
        check("ramp_lost", 32'(bus.sync_lost), 32'd0);
`endif

        // 50% valid gaps, with sync_in toggling on idle cycles that must be ignored.
        do_reset();
        n = 0;
        for (int c = 0; c < 3000 && n < 320; c++) begin
            v  = 1'b1;
            if (n != 0) v = 1'($urandom_range(0, 1));
            re = 16'(16'h1000 + n);
            if (v) begin
                step(n == 0, 1'b1, re, ~re);
                check_beat("gap", n, re, ~re, 1'b0);
                n++;
            end else begin
                step(1'($urandom_range(0, 1)), 1'b0, 16'($urandom), 16'($urandom));
                check_quiet("gap_idle");
            end
        end
        check("gap_budget", 32'(n), 32'd320);

        // Resync at useful sample 5 of symbol 3 (absolute sample 71).
        do_reset();
        eop_n = 0;
        for (int i = 0; i < 71; i++) begin
            re = 16'(16'h2000 + i);
            step(i == 0, 1'b1, re, re);
            check_beat("pre_resync", i, re, re, 1'b0);
        end
        check("pre_resync_eops", 32'(eop_n), 32'd3);
        m = 0;
        for (int i = 0; i < 70; i++) begin
            re = 16'(16'h3000 + i);
            step(i == 0, 1'b1, re, re);
            check_beat("resync", m, re, re, i == 0);
            m++;
            if (i == 0) check("trunc_no_eop", 32'(eop_n), 32'd3);
        end
`ifdef CP_REMOVE_TAGGER_STATUS_EN
        check("resync_lost", 32'(bus.sync_lost), 32'd1);
`endif

        // Asynchronous reset while symbol 1 is in DATA.
        do_reset();
        for (int i = 0; i < 31; i++) begin
            re = 16'(16'h4000 + i);
            step(i == 0, 1'b1, re, re);
            check_beat("pre_rst", i, re, re, 1'b0);
        end
        rst_n = 1'b0;
        #2;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 16'h7fff, 16'h7fff);
            check_quiet("post_rst_nosync");
        end
        for (int i = 0; i < 30; i++) begin
            re = 16'(16'h5000 + i);
            step(i == 0, 1'b1, re, re);
            check_beat("post_rst", i, re, re, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
